// File: rtl/package_settings.sv
// Project-wide data-path settings shared by the acquisition blocks.
package package_settings;
  localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/trap_ctrl_pkg.sv
// Shared types and reset defaults for the trapezoidal filter controller.
package trap_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SETTLE,
    ST_ARMED,
    ST_PEAK
  } state_t;

  localparam logic [7:0] K_RST     = 8'd8;
  localparam logic [7:0] L_RST     = 8'd16;
  localparam logic [7:0] M_RST     = 8'd1;
  localparam int         FLUSH_CYC = 2;

  // A usable trapezoid needs a non-empty rise, a flat top no shorter than it, and M>0.
  function automatic logic cfg_ok(input logic [7:0] k, input logic [7:0] l, input logic [7:0] m);
    return (k != 8'd0) && (l >= k) && (m != 8'd0);
  endfunction
endpackage

// File: rtl/trap_peak_detect.sv
// Pulse start/end detection and peak value/timestamp capture for the filter output.
module trap_peak_detect #(
  parameter int ACC_W = 24,
  parameter int TS_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    track,
  input  logic signed [ACC_W-1:0] filt_data,
  input  logic signed [ACC_W-1:0] threshold,
  input  logic [TS_W-1:0]         ts,
  output logic                    start,
  output logic                    done,
  output logic signed [ACC_W-1:0] peak_amp,
  output logic [TS_W-1:0]         peak_ts
);
  assign start = arm && (filt_data > threshold);
  assign done  = track && (filt_data <= threshold);

  // Strictly-greater update keeps the earliest timestamp on a flat top.
  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_amp <= '0;
      peak_ts  <= '0;
    end else if (start || (track && (filt_data > peak_amp))) begin
      peak_amp <= filt_data;
      peak_ts  <= ts;
    end
  end
endmodule

// File: rtl/trap_filter_ctrl.sv
// Trapezoidal filter controller: config shadowing, flush/settle sequencing, event handshake.
// Define TRAP_CTRL_DROP_CNT_EN to enable the saturating dropped-event counter.
module trap_filter_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
  parameter int ACC_W         = 24,
  parameter int TS_W          = 32,
  parameter int SETTLE_EXTRA  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_wr,
  input  logic [7:0]              cfg_k,
  input  logic [7:0]              cfg_l,
  input  logic [7:0]              cfg_m,
  output logic                    cfg_busy,
  output logic                    cfg_err,
  output logic [7:0]              k_act,
  output logic [7:0]              l_act,
  output logic [7:0]              m_act,
  output logic                    filt_rst_n,
  input  logic signed [ACC_W-1:0] filt_data,
  input  logic signed [ACC_W-1:0] threshold,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic signed [ACC_W-1:0] evt_amp,
  output logic [TS_W-1:0]         evt_ts,
  output logic [15:0]             evt_drop_cnt
);
  if (ACC_W < SIZE_ADC_DATA) begin : g_w_chk
    $error("ACC_W narrower than the ADC input");
  end

  state_t                  state, state_nx;
  logic [15:0]             cnt, cnt_nx, settle_len;
  logic [TS_W-1:0]         ts;
  logic                    pend, cfg_acc, apply, evt_prod;
  logic [7:0]              sh_k, sh_l, sh_m;
  logic                    pk_start, pk_done;
  logic signed [ACC_W-1:0] peak_amp;
  logic [TS_W-1:0]         peak_ts;

  assign settle_len = 16'(k_act) + 16'(l_act) + 16'(SETTLE_EXTRA);
  assign filt_rst_n = !(state == ST_IDLE || state == ST_FLUSH);
  assign cfg_busy   = (state == ST_IDLE) || (state == ST_FLUSH) || (state == ST_SETTLE) || pend;
  assign cfg_acc    = cfg_wr && !cfg_busy && cfg_ok(cfg_k, cfg_l, cfg_m);

  trap_peak_detect #(.ACC_W(ACC_W), .TS_W(TS_W)) u_peak (
    .clk       (clk),
    .reset     (reset),
    .arm       ((state == ST_ARMED) && !pend),
    .track     (state == ST_PEAK),
    .filt_data (filt_data),
    .threshold (threshold),
    .ts        (ts),
    .start     (pk_start),
    .done      (pk_done),
    .peak_amp  (peak_amp),
    .peak_ts   (peak_ts)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ts    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ts    <= ts + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    apply    = 1'b0;
    evt_prod = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nx = ST_FLUSH;
        cnt_nx   = '0;
      end
      ST_FLUSH:
        if (cnt == 16'(FLUSH_CYC - 1)) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 16'd1;
      ST_SETTLE:
        if (cnt == settle_len - 16'd1) begin
          state_nx = ST_ARMED;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 16'd1;
      ST_ARMED:
        if (pend) begin
          apply    = 1'b1;
          state_nx = ST_FLUSH;
          cnt_nx   = '0;
        end else if (pk_start) state_nx = ST_PEAK;
      ST_PEAK:
        // The finished pulse is reported before a pending config flushes the filter.
        if (pk_done) begin
          evt_prod = 1'b1;
          if (pend) begin
            apply    = 1'b1;
            state_nx = ST_FLUSH;
            cnt_nx   = '0;
          end else state_nx = ST_ARMED;
        end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend    <= 1'b0;
      cfg_err <= 1'b0;
      sh_k    <= K_RST;
      sh_l    <= L_RST;
      sh_m    <= M_RST;
      k_act   <= K_RST;
      l_act   <= L_RST;
      m_act   <= M_RST;
    end else begin
      cfg_err <= cfg_wr && !cfg_acc;
      if (cfg_acc) begin
        pend <= 1'b1;
        sh_k <= cfg_k;
        sh_l <= cfg_l;
        sh_m <= cfg_m;
      end else if (apply) begin
        pend  <= 1'b0;
        k_act <= sh_k;
        l_act <= sh_l;
        m_act <= sh_m;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_amp   <= '0;
      evt_ts    <= '0;
    end else if (evt_prod && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_amp   <= peak_amp;
      evt_ts    <= peak_ts;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

`ifdef TRAP_CTRL_DROP_CNT_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk) begin
    if (!reset) drop_q <= '0;
    else if (evt_prod && evt_valid && !evt_ready && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
  end
  assign evt_drop_cnt = drop_q;
`else
  assign evt_drop_cnt = '0;
`endif
endmodule

// File: doc/trap_filter_ctrl.md
TRAP_FILTER_CTRL -- requirements
Module: trap_filter_ctrl

Interface
REQ-001 Parameter SIZE_ADC_DATA, default 12: filter input ADC width.
REQ-002 Parameter ACC_W, default 24: width of the filter output sample.
REQ-003 Parameter TS_W, default 32: timestamp width.
REQ-004 Parameter SETTLE_EXTRA, default 4: extra settle cycles after the k+l flush window.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-low.
REQ-007 cfg_wr  in  1  single-cycle config write strobe.
REQ-008 cfg_k, cfg_l, cfg_m  in  8 each  requested filter k, l, M.
REQ-009 cfg_busy  out  1  config pending or filter not yet settled.
REQ-010 cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-011 k_act, l_act, m_act  out  8 each  active filter parameters.
REQ-012 filt_rst_n  out  1  active-low reset to the filter datapath.
REQ-013 filt_data  in  signed ACC_W  filter output sample, one per clk.
REQ-014 threshold  in  signed ACC_W  pulse trigger level.
REQ-015 evt_valid  out  1; evt_ready  in  1  event handshake.
REQ-016 evt_amp  out  signed ACC_W  pulse peak value; evt_ts  out  TS_W  timestamp of the peak.
REQ-017 evt_drop_cnt  out  16  saturating count of dropped events.

Function
REQ-018 The FSM SHALL have states IDLE, FLUSH, SETTLE, ARMED, PEAK.
REQ-019 After reset the FSM SHALL pass IDLE->FLUSH on the first cycle.
REQ-020 In FLUSH, filt_rst_n SHALL be low for exactly 2 cycles, then the FSM SHALL enter SETTLE.
REQ-021 In SETTLE, the FSM SHALL count k_act+l_act+SETTLE_EXTRA cycles, then enter ARMED.
REQ-022 cfg_busy SHALL be high in IDLE, FLUSH and SETTLE, and whenever a shadow config is pending.
REQ-023 Config write acceptance and rejection:
- a cfg_wr with cfg_k>=1, cfg_l>=cfg_k and cfg_m>=1 SHALL be latched into the shadow registers when cfg_busy=0;
- any other cfg_wr, including every write while cfg_busy=1, SHALL be rejected with a 1-cycle pulse on cfg_err the next cycle.
REQ-024 Shadow config SHALL be copied to k_act/l_act/m_act and trigger FLUSH as follows:
- in ARMED, on the cycle after acceptance;
- in PEAK, on the cycle the pulse ends, after its event is produced.
REQ-025 ARMED->PEAK SHALL occur when filt_data > threshold; that sample SHALL initialise the peak register.
REQ-026 In PEAK, a sample strictly greater than the stored peak SHALL update the peak value and the peak timestamp; ties SHALL keep the earlier timestamp.
REQ-027 PEAK->ARMED SHALL occur when filt_data <= threshold; on that same cycle the event SHALL be produced, and evt_valid SHALL rise the next cycle.
REQ-028 evt_valid/evt_amp/evt_ts SHALL hold stable until the cycle evt_valid&&evt_ready; evt_valid SHALL drop after that cycle unless a new event is loaded that same cycle.
REQ-029 An event produced while evt_valid=1 and evt_ready=0 SHALL be discarded and SHALL increment evt_drop_cnt, which saturates at 16'hFFFF.
REQ-030 The timestamp SHALL be a free-running TS_W counter, cleared by reset, that wraps modulo 2^TS_W.
REQ-031 A pulse in progress when FLUSH starts SHALL be discarded without producing an event.

Reset
REQ-032 On reset=0:
- state SHALL be IDLE and filt_rst_n=0;
- cfg_busy=1, cfg_err=0;
- k_act=8, l_act=16, m_act=1;
- evt_valid=0, evt_amp=0, evt_ts=0, evt_drop_cnt=0;
- timestamp=0 and shadow pending=0.
REQ-033 Reset asserted mid-pulse or mid-SETTLE SHALL abandon all activity with no event.

Configuration
REQ-034 With macro TRAP_CTRL_DROP_CNT_EN defined, evt_drop_cnt SHALL behave per REQ-029.
REQ-035 Without TRAP_CTRL_DROP_CNT_EN, evt_drop_cnt SHALL be constant 0, and discarding SHALL still occur.

Structure
REQ-036 The state enum typedef and the reset defaults for k/l/M SHALL reside in shared package trap_ctrl_pkg.
REQ-037 SIZE_ADC_DATA SHALL come from package_settings.
REQ-038 Peak tracking (REQ-025..027) SHALL be a sub-module trap_peak_detect; FSM, config and handshake logic SHALL stay in trap_filter_ctrl.

Verification
REQ-039 Reset release: filt_rst_n low 2 cycles after IDLE, then SETTLE; cfg_busy falls exactly 8+16+4=28 cycles after SETTLE entry.
REQ-040 threshold=100, filt_data ramp 50,150,300,300,200,90 with evt_ready=1: one event with evt_amp=300 and the timestamp of the first 300.
REQ-041 Two pulses with evt_ready=0: first event held stable, second dropped, evt_drop_cnt=1; evt_ready=1 then completes the first event.
REQ-042 Config writes:
- cfg_wr k=4,l=2 in ARMED gives cfg_err pulse and parameters unchanged;
- cfg_wr k=4,l=10,m=3 gives FLUSH, then SETTLE of 18 cycles, and k_act=4.
REQ-043 cfg_wr accepted, then a pulse begins before the apply cycle: pulse event delivered first, then FLUSH; reset pulled low mid-PEAK produces no event.
